// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM slave port between the instruction fetch unit
// (read only) and the load/store unit (read and write). One transaction is
// owned at a time, round-robin between IFU and LSU, with LSU writes ahead of
// LSU reads. Every grant costs one idle arbitration cycle.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU read bundle
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read bundle
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // LSU write bundle
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  // Slave bundle toward the SRAM
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [7:0]            s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_lastGrantLsu;
  logic   w_nextLastGrantLsu;
  logic   r_addrDone;
  logic   w_nextAddrDone;
  logic   r_dataDone;
  logic   w_nextDataDone;

  logic w_ifuReq;
  logic w_lsuWrReq;
  logic w_lsuReq;

  assign w_ifuReq   = ifu_arvalid;
  assign w_lsuWrReq = lsu_awvalid & lsu_wvalid;
  assign w_lsuReq   = lsu_arvalid | w_lsuWrReq;

  // State register; reset leaves LSU as last grant so the IFU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_lastGrantLsu <= 1'b1;
      r_addrDone     <= 1'b0;
      r_dataDone     <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_lastGrantLsu <= w_nextLastGrantLsu;
      r_addrDone     <= w_nextAddrDone;
      r_dataDone     <= w_nextDataDone;
    end
  end

  // Arbitration, channel steering to the owner, and single-acceptance tracking.
  always_comb begin
    ifu_arready        = 1'b0;
    ifu_rdata          = '0;
    ifu_rresp          = '0;
    ifu_rvalid         = 1'b0;
    lsu_arready        = 1'b0;
    lsu_rdata          = '0;
    lsu_rresp          = '0;
    lsu_rvalid         = 1'b0;
    lsu_awready        = 1'b0;
    lsu_wready         = 1'b0;
    lsu_bresp          = '0;
    lsu_bvalid         = 1'b0;
    s_araddr           = '0;
    s_arvalid          = 1'b0;
    s_rready           = 1'b0;
    s_awaddr           = '0;
    s_awvalid          = 1'b0;
    s_wdata            = '0;
    s_wstrb            = '0;
    s_wvalid           = 1'b0;
    s_bready           = 1'b0;
    w_nextState        = r_state;
    w_nextLastGrantLsu = r_lastGrantLsu;
    w_nextAddrDone     = r_addrDone;
    w_nextDataDone     = r_dataDone;

    unique case (r_state)
      IDLE: begin
        w_nextAddrDone = 1'b0;
        w_nextDataDone = 1'b0;
        if (w_ifuReq && (!w_lsuReq || r_lastGrantLsu)) begin
          w_nextState        = IFU_RD;
          w_nextLastGrantLsu = 1'b0;
        end else if (w_lsuReq) begin
          w_nextState        = w_lsuWrReq ? LSU_WR : LSU_RD;
          w_nextLastGrantLsu = 1'b1;
        end
      end

      IFU_RD: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~r_addrDone;
        ifu_arready = s_arready & ~r_addrDone;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
        if (s_arvalid && s_arready) w_nextAddrDone = 1'b1;
        if (s_rvalid && s_rready) begin
          w_nextState    = IDLE;
          w_nextAddrDone = 1'b0;
        end
      end

      LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~r_addrDone;
        lsu_arready = s_arready & ~r_addrDone;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
        if (s_arvalid && s_arready) w_nextAddrDone = 1'b1;
        if (s_rvalid && s_rready) begin
          w_nextState    = IDLE;
          w_nextAddrDone = 1'b0;
        end
      end

      LSU_WR: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid & ~r_addrDone;
        lsu_awready = s_awready & ~r_addrDone;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid & ~r_dataDone;
        lsu_wready  = s_wready & ~r_dataDone;
        lsu_bresp   = s_bresp;
        lsu_bvalid  = s_bvalid;
        s_bready    = lsu_bready;
        if (s_awvalid && s_awready) w_nextAddrDone = 1'b1;
        if (s_wvalid && s_wready) w_nextDataDone = 1'b1;
        if (s_bvalid && s_bready) begin
          w_nextState    = IDLE;
          w_nextAddrDone = 1'b0;
          w_nextDataDone = 1'b0;
        end
      end

      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven check of the memory arbiter plus
// hand-written multi-cycle sequences for data steering, ties, backpressure,
// reset abort and single address acceptance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [7:0]  lsu_wstrb, s_wstrb;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, s_rresp, s_bresp;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One table row: control inputs for a cycle and the handshake outputs expected in it.
  // stim = {ifuArv,lsuArv,lsuAwv,lsuWv, sArready,sRvalid,sBvalid,ifuRready, lsuRready,lsuBready,sAwready,sWready}
  // exp  = {sArvalid,sRready, ifuArready,ifuRvalid,lsuArready,lsuRvalid, sAwvalid,sWvalid,lsuBvalid,sBready}
  typedef struct {
    string       name;
    logic [11:0] stim;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] sampleVec();
    return {s_arvalid, s_rready, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
            s_awvalid, s_wvalid, lsu_bvalid, s_bready};
  endfunction

  task automatic applyStimulus(input logic [11:0] v);
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid,
     s_arready, s_rvalid, s_bvalid, ifu_rready,
     lsu_rready, lsu_bready, s_awready, s_wready} = v;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(12'h000);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int awCount, wCount, arCount;
    logic [1:0] tieExp[6];

    ifu_araddr = 32'h8000_0000;
    lsu_araddr = 32'h8000_0200;
    lsu_awaddr = 32'h8000_0100;
    lsu_wdata  = 32'hDEAD_BEEF;
    lsu_wstrb  = 8'h04;
    s_rdata    = 32'h0000_0413;
    s_rresp    = 2'b00;
    s_bresp    = 2'b00;
    applyStimulus(12'h000);
    rst_n = 1'b0;

    // Reset state: every request asserted while reset is low must produce nothing.
    @(negedge clk);
    applyStimulus(12'hFFF);
    #1;
    checkOutput("reset_outputs", {54'd0, sampleVec()}, 64'd0);
    checkOutput("reset_wr_ready", {62'd0, lsu_awready, lsu_wready}, 64'd0);
    doReset();

    // Table of consecutive cycles starting from IDLE with last grant = LSU.
    vecs.push_back('{name:"r00_idle_ifu",    stim:12'b1000_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r01_ifu_ar",      stim:12'b1000_1001_1111, exp:10'b11_1000_0000});
    vecs.push_back('{name:"r02_ifu_ardone",  stim:12'b1000_1001_1111, exp:10'b01_0000_0000});
    vecs.push_back('{name:"r03_ifu_r",       stim:12'b0000_1101_1111, exp:10'b01_0100_0000});
    vecs.push_back('{name:"r04_idle_tie",    stim:12'b1100_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r05_lsu_ar",      stim:12'b1100_1001_1111, exp:10'b11_0010_0000});
    vecs.push_back('{name:"r06_lsu_r",       stim:12'b1100_0101_1111, exp:10'b01_0001_0000});
    vecs.push_back('{name:"r07_idle_tie",    stim:12'b1100_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r08_ifu_ar_r",    stim:12'b1100_1101_1111, exp:10'b11_1100_0000});
    vecs.push_back('{name:"r09_idle_tie",    stim:12'b1100_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r10_lsu_ar_bp",   stim:12'b1100_1001_0111, exp:10'b10_0010_0000});
    vecs.push_back('{name:"r11_lsu_r_bp",    stim:12'b1100_0101_0111, exp:10'b00_0001_0000});
    vecs.push_back('{name:"r12_lsu_r_go",    stim:12'b1100_0101_1111, exp:10'b01_0001_0000});
    vecs.push_back('{name:"r13_idle_wr",     stim:12'b0111_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r14_wr_w_only",   stim:12'b0111_0001_1101, exp:10'b00_0000_1101});
    vecs.push_back('{name:"r15_wr_aw",       stim:12'b0111_0001_1111, exp:10'b00_0000_1001});
    vecs.push_back('{name:"r16_wr_b_bp",     stim:12'b0111_0011_1011, exp:10'b00_0000_0010});
    vecs.push_back('{name:"r17_wr_b",        stim:12'b0100_0011_1111, exp:10'b00_0000_0011});
    vecs.push_back('{name:"r18_idle_rd",     stim:12'b0100_0001_1111, exp:10'b00_0000_0000});
    vecs.push_back('{name:"r19_lsu_ar_r",    stim:12'b0100_1101_1111, exp:10'b11_0011_0000});
    vecs.push_back('{name:"r20_idle_none",   stim:12'b0000_0001_1111, exp:10'b00_0000_0000});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      #1;
      checkOutput(vecs[i].name, {54'd0, sampleVec()}, {54'd0, vecs[i].exp});
      nextCycle();
    end

    // IFU-only read: address and returned data steered to the IFU only.
    doReset();
    applyStimulus(12'b1000_0001_1111);
    s_rdata = 32'h0000_0413;
    #1;
    checkOutput("ifu_idle_cycle", {63'd0, s_arvalid}, 64'd0);
    nextCycle();
    s_arready = 1'b1;
    #1;
    checkOutput("ifu_grant_arvalid", {63'd0, s_arvalid}, 64'd1);
    checkOutput("ifu_araddr", {32'd0, s_araddr}, {32'd0, 32'h8000_0000});
    nextCycle();
    s_arready   = 1'b0;
    ifu_arvalid = 1'b0;
    #1;
    checkOutput("ifu_wait_lsu_quiet", {61'd0, lsu_arready, lsu_rvalid, lsu_bvalid}, 64'd0);
    nextCycle();
    s_rvalid = 1'b1;
    #1;
    checkOutput("ifu_rvalid", {63'd0, ifu_rvalid}, 64'd1);
    checkOutput("ifu_rdata", {32'd0, ifu_rdata}, {32'd0, 32'h0000_0413});
    checkOutput("lsu_rdata_blocked", {31'd0, lsu_rvalid, lsu_rdata}, 64'd0);
    nextCycle();
    s_rvalid = 1'b0;
    #1;
    checkOutput("ifu_back_idle", {63'd0, ifu_rvalid}, 64'd0);

    // Tie from reset: IFU, idle, LSU, idle, IFU with both requests held.
    doReset();
    applyStimulus(12'b1100_1101_1111);
    tieExp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("tie_cycle%0d", i), {62'd0, ifu_arready, lsu_arready}, {62'd0, tieExp[i]});
      nextCycle();
    end

    // Write beats read; exactly one aw and one w reach the slave, then the read follows.
    doReset();
    applyStimulus(12'b0111_0001_1111);
    s_bresp = 2'b10;
    nextCycle();
    awCount = 0;
    wCount  = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 0) begin
        checkOutput("wr_awaddr", {32'd0, s_awaddr}, {32'd0, 32'h8000_0100});
        checkOutput("wr_wdata", {32'd0, s_wdata}, {32'd0, 32'hDEAD_BEEF});
        checkOutput("wr_wstrb", {56'd0, s_wstrb}, {56'd0, 8'h04});
      end
      checkOutput($sformatf("wr_no_ar%0d", i), {63'd0, s_arvalid}, 64'd0);
      awCount += int'(s_awvalid & s_awready);
      wCount  += int'(s_wvalid & s_wready);
      nextCycle();
    end
    s_bvalid = 1'b1;
    #1;
    checkOutput("wr_bvalid_bresp", {61'd0, lsu_bvalid, lsu_bresp}, {61'd0, 3'b110});
    nextCycle();
    s_bvalid    = 1'b0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    checkOutput("wr_aw_count", 64'(awCount), 64'd1);
    checkOutput("wr_w_count", 64'(wCount), 64'd1);
    #1;
    checkOutput("wr_then_idle", {63'd0, s_arvalid}, 64'd0);
    nextCycle();
    #1;
    checkOutput("wr_then_read", {31'd0, s_arvalid, s_araddr}, {31'd0, 1'b1, 32'h8000_0200});

    // Backpressure: IFU holds rready low, LSU waits until the read drains.
    doReset();
    applyStimulus(12'b1000_1001_1111);
    nextCycle();
    nextCycle();
    ifu_arvalid = 1'b0;
    s_arready   = 1'b0;
    ifu_rready  = 1'b0;
    s_rvalid    = 1'b1;
    lsu_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_hold%0d", i), {60'd0, s_rready, ifu_rvalid, lsu_arready, s_arvalid},
                  {60'd0, 4'b0100});
      nextCycle();
    end
    ifu_rready = 1'b1;
    #1;
    checkOutput("bp_release", {63'd0, s_rready}, 64'd1);
    nextCycle();
    s_rvalid  = 1'b0;
    s_arready = 1'b1;
    #1;
    checkOutput("bp_idle_gap", {63'd0, s_arvalid}, 64'd0);
    nextCycle();
    #1;
    checkOutput("bp_lsu_granted", {30'd0, s_arvalid, lsu_arready, s_araddr}, {30'd0, 2'b11, 32'h8000_0200});

    // Reset in the middle of an LSU read aborts it; the late response is dropped.
    doReset();
    applyStimulus(12'b0100_1001_1111);
    nextCycle();
    #1;
    checkOutput("rst_lsu_ar", {63'd0, s_arvalid}, 64'd1);
    nextCycle();
    s_arready   = 1'b0;
    lsu_arvalid = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", {54'd0, sampleVec()}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("rst_no_fwd%0d", i), {61'd0, lsu_rvalid, ifu_rvalid, s_rready}, 64'd0);
      nextCycle();
    end
    s_rvalid = 1'b0;

    // Single acceptance: address accepted on the first grant cycle, response 3 cycles later.
    doReset();
    applyStimulus(12'b1000_1001_1111);
    nextCycle();
    arCount = 0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = (i == 3);
      #1;
      arCount += int'(s_arvalid);
      nextCycle();
    end
    s_rvalid = 1'b0;
    checkOutput("single_ar_count", 64'(arCount), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
